leaf_out_rr_arbiter: RTL
========================

Name: leaf_out_rr_arbiter

Overview:
- Round-robin, burst-granular arbiter that lets NUM_REQ HLS kernel output streams share one leaf_interface user-to-interface port.
- Sits inside a leaf wrapper, between the kernels' Output_*_V_TDATA/TVALID/TREADY streams and the interface's din_leaf_user2interface/vld_user2interface/ack_interface2user.
- Holds a grant for up to BURST_LEN beats so a kernel's words stay contiguous in the BFT stream.

Parameters:
- NUM_REQ, 4, number of requesting streams (2..8).
- PAYLOAD_BITS, 32, data width per beat.
- BURST_LEN, 16, max beats per grant (1..256).
- IDLE_TIMEOUT, 8, consecutive non-valid cycles by the granted requester before the grant is released (1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_data  in  NUM_REQ*PAYLOAD_BITS  requester payloads; requester i uses bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- req_vld  in  NUM_REQ  per-requester valid.
- req_ack  out  NUM_REQ  per-requester ready/ack.
- dout  out  PAYLOAD_BITS  to din_leaf_user2interface.
- dout_vld  out  1  to vld_user2interface.
- dout_ack  in  1  from ack_interface2user.
- grant_id  out  $clog2(NUM_REQ) (min 1)  index of the current owner, valid while busy=1.
- busy  out  1  a grant is held.

Behaviour:
- Only one clock domain (clk). Reset is synchronous and active-high.
- Transfer rule: a beat transfers on any cycle where dout_vld=1 and dout_ack=1.
- Reset values: state=IDLE, busy=0, grant_id=0, req_ack=0, dout_vld=0, beat_cnt=0, idle_cnt=0, rr_ptr=0.
- FSM IDLE:
  - Outputs: dout_vld=0, req_ack=0.
  - If any req_vld bit is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Register the pick as grant_id, set busy=1, go to GRANT.
  - Grant latency is 1 cycle from req_vld to dout_vld.
- FSM GRANT (combinational passthrough, no buffering):
  - dout = req_data[grant_id]; dout_vld = req_vld[grant_id].
  - req_ack[grant_id] = dout_ack; all other req_ack bits are 0.
  - beat_cnt increments on each transfer.
  - idle_cnt increments on each cycle with req_vld[grant_id]=0 and resets to 0 when req_vld[grant_id]=1.
- GRANT to RELEASE triggers:
  - a transfer with beat_cnt==BURST_LEN-1, or
  - idle_cnt reaching IDLE_TIMEOUT-1 on a cycle where req_vld[grant_id]=0.
- RELEASE (1 cycle):
  - dout_vld=0, req_ack=0, busy=0.
  - rr_ptr=(grant_id+1) mod NUM_REQ; clear beat_cnt and idle_cnt; go to IDLE.
  - This guarantees a one-cycle gap between bursts.
- Backpressure: dout_ack=0 does not advance beat_cnt. A held valid with dout_ack=0 never counts as idle.
- Fairness: a requester asserting continuously gets at most BURST_LEN beats per turn. With all NUM_REQ requesters active, each is served within (NUM_REQ-1)*(BURST_LEN+2) cycles of losing the grant.
- Non-granted requesters see req_ack=0 and must hold their data (AXI-stream rule).
- Reset mid-burst: the next cycle returns to IDLE with all outputs at reset values. A partially sent burst is not resumed.
- Single requester: re-granted after the RELEASE+IDLE gap (2 idle cycles between bursts).

Optional Feature:
- Macro: LEAF_ARB_STATS_EN.
- Defined:
  - Adds output stat_beats, width NUM_REQ*32: per-requester 32-bit counters of transferred beats, wrapping at 2^32, cleared by reset.
  - Adds input stat_clr, 1 bit: synchronous clear of all counters.
  - A transfer and stat_clr in the same cycle leaves the counter at 0.
- Undefined: neither port exists and no counter logic is generated. Arbitration behaviour is identical.

Test Plan:
- Single requester: NUM_REQ=4, req_vld[2]=1 with 20 beats, dout_ack=1 throughout.
  - Expect grant_id=2 one cycle after req_vld, 16 contiguous beats, a 2-cycle gap, then the remaining 4 beats.
- All requesters: all four assert continuously with dout_ack=1.
  - Expect grant order 0,1,2,3,0; each burst exactly 16 beats; dout matches the owner's data.
- Backpressure: requester 1 bursting, dout_ack toggles 1,0,1,0.
  - Expect beat_cnt to advance only on ack cycles; no release before 16 transfers; req_ack[1] mirrors dout_ack.
- Idle timeout: requester 0 sends 3 beats then drops req_vld while requester 3 is valid.
  - Expect release after 8 idle cycles, then grant_id=3.
- Reset mid-burst: assert reset at beat 7 of requester 1.
  - Expect next cycle busy=0, dout_vld=0, req_ack=0; after reset, requester 0 is granted first (rr_ptr=0).
- With LEAF_ARB_STATS_EN defined: 16 beats from requester 0 and 5 from requester 2.
  - Expect stat_beats = {0, 5, 0, 16} (index 3 down to 0).
  - Pulsing stat_clr gives all zeros next cycle.

Source files
------------

// File: rtl/leaf_out_rr_arbiter.sv
// leaf_out_rr_arbiter: lets NUM_REQ kernel output streams share one
// leaf_interface user-to-interface port. Grants are burst-granular: the owner
// keeps the port for up to BURST_LEN beats, or until it has left its valid low
// for IDLE_TIMEOUT consecutive cycles. Each release is followed by a one-cycle
// gap, and the next owner is picked round-robin starting after the last one.
// Data, valid and ready pass through combinationally, with no buffering.
//
// Optional build macro LEAF_ARB_STATS_EN adds per-requester 32-bit beat
// counters (output stat_beats) with a synchronous clear input (stat_clr).
module leaf_out_rr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int BURST_LEN    = 16,
  parameter int IDLE_TIMEOUT = 8,
  localparam int GIDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [PAYLOAD_BITS-1:0]         dout,
  output logic                            dout_vld,
  input  logic                            dout_ack,
  output logic [GIDW-1:0]                 grant_id,
  output logic                            busy
`ifdef LEAF_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]           stat_beats,
  input  logic                            stat_clr
`endif
);

  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam int ICW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_LEN - 1);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_TIMEOUT - 1);
  localparam logic [GIDW-1:0] GID_LAST = GIDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                  state;
  logic [BCW-1:0]          beat_cnt;
  logic [ICW-1:0]          idle_cnt;
  logic [GIDW-1:0]         rr_ptr;

  logic [PAYLOAD_BITS-1:0] lane [NUM_REQ];
  logic                    owner_vld;
  logic                    xfer;
  logic                    last_beat;
  logic                    timed_out;
  logic [GIDW-1:0]         pick;
  logic [GIDW-1:0]         next_ptr;

  // First requesting index at or after ptr, wrapping past NUM_REQ-1 to 0.
  function automatic logic [GIDW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [GIDW-1:0]    ptr);
    logic [2*NUM_REQ-1:0] dbl;
    logic [GIDW-1:0]      sel;
    logic                 found;
    int                   idx;
    dbl   = {vld, vld} >> ptr;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && dbl[k]) begin
        sel   = GIDW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Split the flat payload bus into per-requester lanes.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) lane[i] = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  // Owner passthrough and the release conditions seen by the FSM.
  always_comb begin
    owner_vld = req_vld[grant_id];
    dout      = lane[grant_id];
    dout_vld  = (state == S_GRANT) && owner_vld;
    req_ack   = '0;
    if (state == S_GRANT) req_ack[grant_id] = dout_ack;
    xfer      = dout_vld && dout_ack;
    last_beat = xfer && (beat_cnt == BEAT_LAST);
    timed_out = (state == S_GRANT) && !owner_vld && (idle_cnt == IDLE_LAST);
    pick      = rr_pick(req_vld, rr_ptr);
    next_ptr  = (grant_id == GID_LAST) ? '0 : grant_id + GIDW'(1);
  end

  // Arbitration FSM: pick in IDLE, stream in GRANT, one-cycle RELEASE gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      grant_id <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_vld) begin
            grant_id <= pick;
            busy     <= 1'b1;
            beat_cnt <= '0;
            idle_cnt <= '0;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (xfer) beat_cnt <= beat_cnt + BCW'(1);
          // A stalled but valid owner is not idle.
          if (owner_vld) idle_cnt <= '0;
          else           idle_cnt <= idle_cnt + ICW'(1);
          if (last_beat || timed_out) begin
            busy  <= 1'b0;
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          rr_ptr   <= next_ptr;
          beat_cnt <= '0;
          idle_cnt <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LEAF_ARB_STATS_EN
  logic [31:0] stat_q [NUM_REQ];

  // Per-requester transferred-beat counters; clear wins over a same-cycle beat.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset || stat_clr)                      stat_q[i] <= '0;
      else if (xfer && (grant_id == GIDW'(i)))    stat_q[i] <= stat_q[i] + 32'd1;
    end
  end

  // Flatten the counters onto the stat_beats bus.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) stat_beats[i*32 +: 32] = stat_q[i];
  end
`endif

endmodule
